majority_3: RTL and testbench

Three-input bitwise majority voter with registered fault monitoring, for triple-redundant signal paths (TMR voting of a replicated control bit). The combinational output Y is the majority of A, B and C with zero latency. A clocked monitor section identifies the dissenting input on each cycle, keeps per-input saturating disagreement counters, and holds a sticky fault flag for upstream health logic.

---
 rtl/majority_3.sv | 139 +++++++++++++
 tb/tb_majority_3.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/majority_3.sv
`default_nettype none
// ============================================================================
// Module      : majority_3
// Description : Three-input bitwise majority voter for triple-redundant
//               signal paths. Y is the zero-latency combinational vote.
//               A registered monitor reports which copy dissented each
//               cycle, keeps a saturating disagreement counter per copy
//               and holds a sticky fault flag for upstream health logic.
// Revision    : 1.0 - initial release
// ============================================================================
module majority_3 #(
   parameter int CNT_W = 8    // disagreement counter width, 1..16
) (
   input  logic             A,
   input  logic             B,
   input  logic             C,
   output logic             Y,
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   output logic             y_q,
   output logic             mismatch,
   output logic [1:0]       minority,
   output logic [CNT_W-1:0] err_cnt_a,
   output logic [CNT_W-1:0] err_cnt_b,
   output logic [CNT_W-1:0] err_cnt_c,
   output logic             fault
);

   // Dissenter codes as reported on minority.
   localparam logic [1:0] DIS_NONE = 2'd0;
   localparam logic [1:0] DIS_A    = 2'd1;
   localparam logic [1:0] DIS_B    = 2'd2;
   localparam logic [1:0] DIS_C    = 2'd3;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   // Combinational decode of the current input set.
   logic       vote;
   logic [1:0] dis_code;
   logic       dis_any;

   // Next-state values for every flop.
   logic             y_d;
   logic             mismatch_q,  mismatch_d;
   logic [1:0]       minority_q,  minority_d;
   logic [CNT_W-1:0] cnt_a_q,     cnt_a_d;
   logic [CNT_W-1:0] cnt_b_q,     cnt_b_d;
   logic [CNT_W-1:0] cnt_c_q,     cnt_c_d;
   logic             fault_q,     fault_d;

   // Saturating increment: an all-ones counter holds instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
      if (cnt == CNT_MAX) begin
         return cnt;
      end
      return cnt + CNT_ONE;
   endfunction

   // Majority vote: depends only on the three copies, never on clk/rst/clr,
   // so a voter instantiated with just A/B/C/Y connected still works.
   assign vote = (A & B) | (A & C) | (B & C);
   assign Y    = vote;

   // Dissenter decode: when the copies are not unanimous, exactly one of
   // them disagrees with the other two, and the pair that matches names it.
   always_comb begin
      dis_code = DIS_NONE;
      if ((A == B) && (B == C)) begin
         dis_code = DIS_NONE;
      end else if (B == C) begin
         dis_code = DIS_A;
      end else if (A == C) begin
         dis_code = DIS_B;
      end else begin
         dis_code = DIS_C;
      end
   end

   assign dis_any = (dis_code != DIS_NONE);

   // Next-state logic: status follows the inputs every cycle; counters and
   // the sticky flag are cleared by clr, which wins over any same-cycle
   // increment or fault set. Only the dissenter's counter can move.
   always_comb begin
      y_d        = vote;
      mismatch_d = dis_any;
      minority_d = dis_code;
      cnt_a_d    = cnt_a_q;
      cnt_b_d    = cnt_b_q;
      cnt_c_d    = cnt_c_q;
      fault_d    = fault_q;
      if (clr) begin
         cnt_a_d = '0;
         cnt_b_d = '0;
         cnt_c_d = '0;
         fault_d = 1'b0;
      end else begin
         fault_d = fault_q | dis_any;
         case (dis_code)
            DIS_A:   cnt_a_d = sat_inc(cnt_a_q);
            DIS_B:   cnt_b_d = sat_inc(cnt_b_q);
            DIS_C:   cnt_c_d = sat_inc(cnt_c_q);
            default: ;
         endcase
      end
   end

   // Monitor registers, asynchronously cleared by rst.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         y_q        <= 1'b0;
         mismatch_q <= 1'b0;
         minority_q <= DIS_NONE;
         cnt_a_q    <= '0;
         cnt_b_q    <= '0;
         cnt_c_q    <= '0;
         fault_q    <= 1'b0;
      end else begin
         y_q        <= y_d;
         mismatch_q <= mismatch_d;
         minority_q <= minority_d;
         cnt_a_q    <= cnt_a_d;
         cnt_b_q    <= cnt_b_d;
         cnt_c_q    <= cnt_c_d;
         fault_q    <= fault_d;
      end
   end

   assign mismatch  = mismatch_q;
   assign minority  = minority_q;
   assign err_cnt_a = cnt_a_q;
   assign err_cnt_b = cnt_b_q;
   assign err_cnt_c = cnt_c_q;
   assign fault     = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_majority_3.sv
`default_nettype none
// ============================================================================
// Module      : tb_majority_3
// Description : Self-checking bench for majority_3. Two instances share the
//               stimulus: one at the default counter width and one at
//               CNT_W=2 to reach saturation quickly. A reference model
//               pushes expected monitor state into a scoreboard queue when
//               inputs are driven; entries are popped after the clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_majority_3;

   localparam int W_BIG = 8;
   localparam int W_SML = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic clr = 1'b0;
   logic A = 1'b0, B = 1'b0, C = 1'b0;
   bit   run_clk = 1'b0;

   logic             y_b, yq_b, mis_b, flt_b;
   logic [1:0]       min_b;
   logic [W_BIG-1:0] ca_b, cb_b, cc_b;
   logic             y_s, yq_s, mis_s, flt_s;
   logic [1:0]       min_s;
   logic [W_SML-1:0] ca_s, cb_s, cc_s;

   majority_3 #(.CNT_W(W_BIG)) u_dut (
      .A(A), .B(B), .C(C), .Y(y_b), .clk(clk), .rst(rst), .clr(clr),
      .y_q(yq_b), .mismatch(mis_b), .minority(min_b),
      .err_cnt_a(ca_b), .err_cnt_b(cb_b), .err_cnt_c(cc_b), .fault(flt_b)
   );

   majority_3 #(.CNT_W(W_SML)) u_dut_small (
      .A(A), .B(B), .C(C), .Y(y_s), .clk(clk), .rst(rst), .clr(clr),
      .y_q(yq_s), .mismatch(mis_s), .minority(min_s),
      .err_cnt_a(ca_s), .err_cnt_b(cb_s), .err_cnt_c(cc_s), .fault(flt_s)
   );

   // Free-running 10 ns clock once enabled; idle low before that.
   always begin
      #5;
      if (run_clk) clk = ~clk;
   end

   typedef struct {
      logic       y;
      logic       mis;
      logic [1:0] mnr;
      int         cnt[3];
      int         scnt[3];
      logic       flt;
   } exp_t;

   exp_t sb_q[$];

   int   n_cmp = 0;
   int   n_err = 0;

   // Reference model state.
   int   m_cnt[3];
   int   s_cnt[3];
   logic m_fault;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_cnt[i] = 0;
         s_cnt[i] = 0;
      end
      m_fault = 1'b0;
   endtask

   // Compare every registered output of both instances against zero.
   task automatic check_reset_state(input string tag);
      check({tag, " y_q"},      32'(yq_b),  0);
      check({tag, " mismatch"}, 32'(mis_b), 0);
      check({tag, " minority"}, 32'(min_b), 0);
      check({tag, " cnt_a"},    32'(ca_b),  0);
      check({tag, " cnt_b"},    32'(cb_b),  0);
      check({tag, " cnt_c"},    32'(cc_b),  0);
      check({tag, " fault"},    32'(flt_b), 0);
      check({tag, " s_cnt"},    32'({ca_s, cb_s, cc_s, flt_s, mis_s}), 0);
   endtask

   // Drive one input vector (called just after a falling edge), record the
   // model's prediction, then compare after the next rising edge.
   task automatic step(input logic a, input logic b, input logic c, input logic cl,
                       input string tag);
      exp_t e;
      int   ones;
      int   dis;
      A = a; B = b; C = c; clr = cl;
      ones = int'(a) + int'(b) + int'(c);
      if (ones == 0 || ones == 3) dis = 0;
      else if (ones == 1)         dis = a ? 1 : (b ? 2 : 3);
      else                        dis = !a ? 1 : (!b ? 2 : 3);
      if (cl) begin
         for (int i = 0; i < 3; i++) begin
            m_cnt[i] = 0;
            s_cnt[i] = 0;
         end
         m_fault = 1'b0;
      end else if (dis != 0) begin
         if (m_cnt[dis-1] < (1 << W_BIG) - 1) m_cnt[dis-1]++;
         if (s_cnt[dis-1] < (1 << W_SML) - 1) s_cnt[dis-1]++;
         m_fault = 1'b1;
      end
      e.y    = (ones >= 2);
      e.mis  = (dis != 0);
      e.mnr  = 2'(dis);
      e.cnt  = m_cnt;
      e.scnt = s_cnt;
      e.flt  = m_fault;
      sb_q.push_back(e);
      #1;
      check({tag, " Y comb"}, 32'({y_s, y_b}), e.y ? 32'd3 : 32'd0);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         check({tag, " scoreboard empty"}, 32'd0, 32'd1);
      end else begin
         e = sb_q.pop_front();
         check({tag, " y_q"},      32'(yq_b),  32'(e.y));
         check({tag, " mismatch"}, 32'(mis_b), 32'(e.mis));
         check({tag, " minority"}, 32'(min_b), 32'(e.mnr));
         check({tag, " cnt_a"},    32'(ca_b),  32'(e.cnt[0]));
         check({tag, " cnt_b"},    32'(cb_b),  32'(e.cnt[1]));
         check({tag, " cnt_c"},    32'(cc_b),  32'(e.cnt[2]));
         check({tag, " fault"},    32'(flt_b), 32'(e.flt));
         check({tag, " s_y_q"},    32'({yq_s, mis_s, min_s}), 32'({e.y, e.mis, e.mnr}));
         check({tag, " s_cnt_a"},  32'(ca_s),  32'(e.scnt[0]));
         check({tag, " s_cnt_b"},  32'(cb_s),  32'(e.scnt[1]));
         check({tag, " s_cnt_c"},  32'(cc_s),  32'(e.scnt[2]));
         check({tag, " s_fault"},  32'(flt_s), 32'(e.flt));
      end
      @(negedge clk);
   endtask

   // Watchdog so the run always ends on its own.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] y_tab;
      logic [2:0] v;
      y_tab = 8'b1110_1000;   // Y for ABC = 7..0

      // Reset held with the clock idle.
      model_reset();
      #1 rst = 1'b1;
      #1;
      check_reset_state("por");

      // Exhaustive vote while the clock is idle.
      for (int i = 0; i < 8; i++) begin
         v = 3'(i);
         {A, B, C} = v;
         #1;
         check($sformatf("vote %0d Y", i),  32'(y_b), 32'(y_tab[i]));
         check($sformatf("vote %0d Ys", i), 32'(y_s), 32'(y_tab[i]));
         #9;
      end

      // Start clock and leave reset between edges.
      run_clk = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      step(1'b1, 1'b0, 1'b0, 1'b0, "first");

      // Async reset mid-operation with ABC=100.
      A = 1'b1; B = 1'b0; C = 1'b0;
      rst = 1'b1;
      #1;
      check_reset_state("async rst");
      model_reset();
      #1 rst = 1'b0;
      step(1'b1, 1'b0, 1'b0, 1'b0, "post rst");

      // Dissenter tracking from a clean state.
      rst = 1'b1;
      model_reset();
      #1 rst = 1'b0;
      repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0, "dis B");
      repeat (2) step(1'b1, 1'b1, 1'b0, 1'b0, "dis C");

      // Saturation at the narrow width: clear, then C dissents 6 times.
      step(1'b1, 1'b1, 1'b1, 1'b1, "clr agree");
      repeat (6) step(1'b0, 1'b0, 1'b1, 1'b0, "sat C");

      // clr beats a same-cycle increment and fault set.
      step(1'b0, 1'b1, 1'b1, 1'b1, "clr prio");
      step(1'b0, 1'b1, 1'b1, 1'b0, "after clr");

      // Agreement leaves counters and fault alone.
      step(1'b1, 1'b1, 1'b1, 1'b0, "agree 1");
      step(1'b0, 1'b0, 1'b0, 1'b0, "agree 0");

      // Random traffic with occasional clr.
      for (int i = 0; i < 40; i++) begin
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0), "rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
